if_id_skid_reg: RTL

- Parametrised IF/ID pipeline boundary register replacing the single-slot stall register.
- Sits between fetch and decode and carries PC and instruction with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Synchronous flush squashes both slots and presents a NOP bubble to decode.

---
 rtl/if_id_skid_reg_pkg.sv | 27 ++
 rtl/if_id_skid_reg_pipe_slot.sv | 57 +++++
 rtl/if_id_skid_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg_pkg
// Shared definitions for the IF/ID skid register:
//   state_e        - occupancy state of the two-slot buffer
//   DEF_NOP_INSTR  - default bubble instruction (addi x0,x0,0)
//   DEF_RESET_PC   - default PC presented after reset/flush
//   state_has_beat - true when the state holds a beat for decode
// ----------------------------------------------------------------------------
package if_id_skid_reg_pkg;

    // EMPTY: nothing held; ONE: main slot valid; FULL: main and skid valid.
    // ST_BAD never occurs in normal operation and falls back to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2,
        ST_BAD   = 2'd3
    } state_e;

    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    function automatic logic state_has_beat(input state_e st);
        return (st != ST_EMPTY);
    endfunction

endpackage

// File: rtl/if_id_skid_reg_pipe_slot.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg_pipe_slot
// One {pc, instr} payload register of the IF/ID skid buffer.
// Ports:
//   i_clk        clock
//   i_res        asynchronous active-high reset (pc <= RST_PC, instr <= NOP)
//   i_load       capture i_pc / i_instr
//   i_clr_instr  force instr to NOP (wins over i_load)
//   i_clr_pc     force pc to RST_PC (wins over i_load)
//   i_pc/i_instr payload in
//   o_pc/o_instr payload out (straight from the flops)
// ----------------------------------------------------------------------------
module if_id_skid_reg_pipe_slot
    import if_id_skid_reg_pkg::*;
#(
    parameter int                   PC_W    = 32,
    parameter int                   INSTR_W = 32,
    parameter logic [PC_W-1:0]      RST_PC  = PC_W'(DEF_RESET_PC),
    parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(DEF_NOP_INSTR)
) (
    input  logic                i_clk,
    input  logic                i_res,
    input  logic                i_load,
    input  logic                i_clr_instr,
    input  logic                i_clr_pc,
    input  logic [PC_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]  i_instr,
    output logic [PC_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]  o_instr
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    // pc and instr clear independently: draining to EMPTY bubbles the
    // instruction but keeps the last PC visible.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_pc    <= RST_PC;
            r_instr <= NOP;
        end else begin
            if (i_clr_pc)
                r_pc <= RST_PC;
            else if (i_load)
                r_pc <= i_pc;

            if (i_clr_instr)
                r_instr <= NOP;
            else if (i_load)
                r_instr <= i_instr;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_id_skid_reg.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline boundary with a 2-entry skid buffer. Gives one beat per
// cycle while in_ready comes straight from the state flops.
// Ports:
//   i_clk        clock
//   i_res        asynchronous active-high reset
//   i_flush      synchronous squash of all held beats
//   i_in_valid   fetch presents a beat
//   o_in_ready   buffer can accept (state != FULL)
//   i_in_pc      fetch PC
//   i_in_instr   fetched instruction
//   o_out_valid  beat valid to decode (state != EMPTY)
//   i_out_ready  decode accepts the beat
//   o_out_pc     PC to decode
//   o_out_instr  instruction to decode, NOP_INSTR when nothing is held
// ----------------------------------------------------------------------------
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                   PC_W      = 32,
    parameter int                   INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter logic [PC_W-1:0]      RESET_PC  = PC_W'(DEF_RESET_PC)
) (
    input  logic                i_clk,
    input  logic                i_res,
    input  logic                i_flush,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [PC_W-1:0]     i_in_pc,
    input  logic [INSTR_W-1:0]  i_in_instr,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [PC_W-1:0]     o_out_pc,
    output logic [INSTR_W-1:0]  o_out_instr
);

    state_e r_state;

    logic w_in_fire;
    logic w_out_fire;

    logic w_main_load;
    logic w_main_from_skid;
    logic w_main_clr_instr;
    logic w_main_clr_pc;
    logic w_skid_load;
    logic w_skid_clr;

    logic [PC_W-1:0]    w_main_pc_d;
    logic [INSTR_W-1:0] w_main_instr_d;
    logic [PC_W-1:0]    w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;

    // Handshake outputs are pure state decodes: no input reaches them
    // combinationally.
    assign o_out_valid = state_has_beat(r_state);
    assign o_in_ready  = (r_state != ST_FULL);

    assign w_in_fire  = i_in_valid & o_in_ready;
    assign w_out_fire = o_out_valid & i_out_ready;

    // ------------------------------------------------------------------
    // Slot control
    // ------------------------------------------------------------------
    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr_instr = 1'b0;
        w_main_clr_pc    = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;

        if (i_flush) begin
            // Flush beats everything, including a beat offered this cycle.
            w_main_clr_instr = 1'b1;
            w_main_clr_pc    = 1'b1;
            w_skid_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_main_load = w_in_fire;
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire)
                        w_main_load = 1'b1;        // pass-through, skid unused
                    else if (w_in_fire)
                        w_skid_load = 1'b1;        // decode stalled: park in skid
                    else if (w_out_fire)
                        w_main_clr_instr = 1'b1;   // drained: bubble, keep pc
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_main_pc_d    = w_main_from_skid ? w_skid_pc    : i_in_pc;
    assign w_main_instr_d = w_main_from_skid ? w_skid_instr : i_in_instr;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state <= ST_EMPTY;
        end else if (i_flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire)
                        r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire)
                        r_state <= ST_FULL;
                    else if (!w_in_fire && w_out_fire)
                        r_state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_out_fire)
                        r_state <= ST_ONE;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload slots
    // ------------------------------------------------------------------
    if_id_skid_reg_pipe_slot #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .RST_PC  (RESET_PC),
        .NOP     (NOP_INSTR)
    ) u_main (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_load      (w_main_load),
        .i_clr_instr (w_main_clr_instr),
        .i_clr_pc    (w_main_clr_pc),
        .i_pc        (w_main_pc_d),
        .i_instr     (w_main_instr_d),
        .o_pc        (o_out_pc),
        .o_instr     (o_out_instr)
    );

    if_id_skid_reg_pipe_slot #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .RST_PC  (RESET_PC),
        .NOP     (NOP_INSTR)
    ) u_skid (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_load      (w_skid_load),
        .i_clr_instr (w_skid_clr),
        .i_clr_pc    (w_skid_clr),
        .i_pc        (i_in_pc),
        .i_instr     (i_in_instr),
        .o_pc        (w_skid_pc),
        .o_instr     (w_skid_instr)
    );

endmodule
